// File: rtl/branch_predict_resolve.sv
// EX-stage branch resolution with a PC-indexed 2-bit BHT predictor,
// misprediction flagging and saturating debug statistics.
module branch_predict_resolve #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [1:0]  CTR_INIT    = 2'b01,
    parameter int unsigned STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   PCD,
    output logic              PredTakenD,
    input  logic [2:0]        BranchTypeE,
    input  logic [XLEN-1:0]   Operand1E,
    input  logic [XLEN-1:0]   Operand2E,
    input  logic [XLEN-1:0]   PCE,
    input  logic              PredTakenE,
    input  logic              ValidE,
    input  logic              StallE,
    output logic              BranchE,
    output logic              MispredictE,
    output logic [STAT_W-1:0] BranchCount,
    output logic [STAT_W-1:0] MispredictCount
);

    localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    localparam logic [2:0] BT_NOBRANCH = 3'd0;
    localparam logic [2:0] BT_BEQ      = 3'd1;
    localparam logic [2:0] BT_BNE      = 3'd2;
    localparam logic [2:0] BT_BLT      = 3'd3;
    localparam logic [2:0] BT_BLTU     = 3'd4;
    localparam logic [2:0] BT_BGE      = 3'd5;
    localparam logic [2:0] BT_BGEU     = 3'd6;

    logic [1:0]        r_bht [BHT_ENTRIES];
    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_mispred_cnt;

    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_eq;
    logic              w_lt_s;
    logic              w_lt_u;
    logic              w_taken;
    logic              w_is_br;
    logic              w_mispred;
    logic              w_update;
    logic [1:0]        w_ctr_cur;
    logic [1:0]        w_ctr_nxt;
    logic              w_unused_pc;

    // PC[1:0] and the bits above the index never select an entry.
    assign w_rd_idx    = PCD[IDX_W+1:2];
    assign w_wr_idx    = PCE[IDX_W+1:2];
    assign w_unused_pc = ^{PCD[XLEN-1:IDX_W+2], PCD[1:0], PCE[XLEN-1:IDX_W+2], PCE[1:0]};

    // Full-width comparisons shared by all branch types.
    assign w_eq   = (Operand1E == Operand2E);
    assign w_lt_s = ($signed(Operand1E) < $signed(Operand2E));
    assign w_lt_u = (Operand1E < Operand2E);

    // Branch outcome and branch qualification; unknown/reserved types resolve to not-a-branch.
    always_comb begin
        w_taken = 1'b0;
        w_is_br = 1'b0;
        case (BranchTypeE)
            BT_BEQ:  begin w_taken = w_eq;    w_is_br = 1'b1; end
            BT_BNE:  begin w_taken = ~w_eq;   w_is_br = 1'b1; end
            BT_BLT:  begin w_taken = w_lt_s;  w_is_br = 1'b1; end
            BT_BLTU: begin w_taken = w_lt_u;  w_is_br = 1'b1; end
            BT_BGE:  begin w_taken = ~w_lt_s; w_is_br = 1'b1; end
            BT_BGEU: begin w_taken = ~w_lt_u; w_is_br = 1'b1; end
            BT_NOBRANCH: begin w_taken = 1'b0; w_is_br = 1'b0; end
            default: begin w_taken = 1'b0; w_is_br = 1'b0; end
        endcase
    end

    // Mispredict is raised regardless of stall; the hazard unit qualifies it.
    assign w_mispred = w_is_br & ValidE & (w_taken ^ PredTakenE);
    assign w_update  = w_is_br & ValidE & ~StallE;

    // Saturating 2-bit counter step for the entry being resolved.
    always_comb begin
        w_ctr_cur = r_bht[w_wr_idx];
        w_ctr_nxt = w_ctr_cur;
        if (w_taken) begin
            if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'(1);
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'(1);
        end
    end

    // Predictor table: written one cycle after resolution, no read bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) r_bht[i] <= CTR_INIT;
        end else if (w_update) begin
            r_bht[w_wr_idx] <= w_ctr_nxt;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_update) begin
            if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + STAT_W'(1);
            if (w_mispred && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
        end
    end

    assign PredTakenD      = r_bht[w_rd_idx][1];
    assign BranchE         = w_taken;
    assign MispredictE     = w_mispred;
    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Randomized + directed bench for branch_predict_resolve against a table-level reference model.
module tb_branch_predict_resolve;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned STAT_W = 4;
    localparam int          STAT_MAX = 15;
    localparam logic [1:0]  INIT = 2'b01;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [XLEN-1:0]   pcd, op1, op2, pce;
    logic [2:0]        btype;
    logic              pred_e, valid, stall;
    logic              pred_d, branch_e, mispred_e;
    logic [STAT_W-1:0] bcnt, mcnt;

    int checks = 0;
    int errors = 0;

    // Reference state: one integer per table entry plus two plain counters.
    int ref_bht [ENTRIES];
    int ref_bcnt;
    int ref_mcnt;

    branch_predict_resolve #(
        .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .CTR_INIT(INIT), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PCD(pcd), .PredTakenD(pred_d),
        .BranchTypeE(btype), .Operand1E(op1), .Operand2E(op2), .PCE(pce),
        .PredTakenE(pred_e), .ValidE(valid), .StallE(stall),
        .BranchE(branch_e), .MispredictE(mispred_e),
        .BranchCount(bcnt), .MispredictCount(mcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int entry_of(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit ref_taken(input int t, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (t)
            1: return ua == ub;
            2: return ua != ub;
            3: return sa < sb;
            4: return ua < ub;
            5: return sa >= sb;
            6: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < int'(ENTRIES); i++) ref_bht[i] = int'(INIT);
        ref_bcnt = 0;
        ref_mcnt = 0;
    endfunction

    task automatic drive(input int t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc_e, input logic [31:0] pc_d,
                         input bit p, input bit v, input bit s);
        btype = 3'(t); op1 = a; op2 = b; pce = pc_e; pcd = pc_d;
        pred_e = p; valid = v; stall = s;
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic do_cycle();
        bit tk, isbr, mis;
        int wi;
        #3;
        tk   = ref_taken(int'(btype), op1, op2);
        isbr = valid && (btype >= 3'd1) && (btype <= 3'd6);
        mis  = isbr && (tk != pred_e);
        wi   = entry_of(pce);
        check("pred_d_pre", 64'(pred_d), 64'(ref_bht[entry_of(pcd)] >= 2));
        check("branch_e", 64'(branch_e), 64'(tk));
        check("mispredict_e", 64'(mispred_e), 64'(mis));
        @(posedge clk);
        if (rst_n && isbr && !stall) begin
            ref_bht[wi] = tk ? ((ref_bht[wi] < 3) ? ref_bht[wi] + 1 : 3)
                             : ((ref_bht[wi] > 0) ? ref_bht[wi] - 1 : 0);
            if (ref_bcnt < STAT_MAX) ref_bcnt++;
            if (mis && ref_mcnt < STAT_MAX) ref_mcnt++;
        end
        #1;
        check("branch_count", 64'(bcnt), 64'(ref_bcnt));
        check("mispredict_count", 64'(mcnt), 64'(ref_mcnt));
        check("pred_d_post", 64'(pred_d), 64'(ref_bht[entry_of(pcd)] >= 2));
    endtask

    // Asynchronous reset between edges; table and counters must clear without a clock.
    task automatic async_reset_check();
        #2;
        rst_n = 1'b0;
        ref_reset();
        #1;
        check("rst_branch_count", 64'(bcnt), 64'd0);
        check("rst_mispredict_count", 64'(mcnt), 64'd0);
        for (int i = 0; i < int'(ENTRIES); i++) begin
            pcd = 32'(i * 4);
            #1;
            check("rst_entry_pred", 64'(pred_d), 64'(INIT[1]));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        ref_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h100, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_pred_d", 64'(pred_d), 64'(INIT[1]));
        check("reset_branch_count", 64'(bcnt), 64'd0);
        check("reset_mispredict_count", 64'(mcnt), 64'd0);
        rst_n = 1'b1;

        // First mispredicted BEQ at 0x100 flips the entry to weak-taken.
        drive(1, 5, 5, 32'h100, 32'h100, 0, 1, 0);
        do_cycle();
        check("first_pred_after", 64'(pred_d), 64'd1);
        check("first_branch_count", 64'(bcnt), 64'd1);
        check("first_mispredict_count", 64'(mcnt), 64'd1);

        // Signed vs unsigned compare of -1 against 1, BNE equal, reserved type.
        drive(3, 32'hFFFF_FFFF, 1, 32'h200, 32'h200, 0, 1, 0); do_cycle();
        drive(4, 32'hFFFF_FFFF, 1, 32'h200, 32'h200, 0, 1, 0); do_cycle();
        drive(5, 32'hFFFF_FFFF, 1, 32'h200, 32'h200, 1, 1, 0); do_cycle();
        drive(6, 32'hFFFF_FFFF, 1, 32'h200, 32'h200, 0, 1, 0); do_cycle();
        drive(2, 32'h1234, 32'h1234, 32'h200, 32'h200, 1, 1, 0); do_cycle();
        drive(7, 5, 5, 32'h200, 32'h200, 1, 1, 0); do_cycle();

        // Saturation at 0x40: 5 taken, then 5 not-taken.
        for (int i = 0; i < 5; i++) begin
            drive(1, 9, 9, 32'h40, 32'h40, 1, 1, 0); do_cycle();
        end
        for (int i = 0; i < 5; i++) begin
            drive(2, 9, 9, 32'h40, 32'h40, 0, 1, 0); do_cycle();
        end

        // Aliasing: 0x4 and 0x104 share an entry.
        drive(1, 3, 3, 32'h4, 32'h104, 0, 1, 0); do_cycle();
        drive(1, 3, 3, 32'h4, 32'h4, 0, 1, 0);   do_cycle();

        // Hold conditions: stalled and bubble taken BEQ.
        drive(1, 7, 7, 32'h80, 32'h80, 0, 1, 1); do_cycle();
        drive(1, 7, 7, 32'h80, 32'h80, 0, 0, 0); do_cycle();

        // Statistics saturation after a fresh reset, then reset mid-burst.
        async_reset_check();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, 32'(i * 4), 32'(i * 4), 0, 1, 0); do_cycle();
        end
        check("sat_branch_count", 64'(bcnt), 64'(STAT_MAX));
        check("sat_mispredict_count", 64'(mcnt), 64'(STAT_MAX));
        drive(1, 1, 1, 32'h8, 32'h8, 0, 1, 0);
        async_reset_check();

        // Randomized traffic over a small PC pool so entries collide.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a, b, pe, pd;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pe = 32'($urandom_range(0, 15) * 4 + ($urandom_range(0, 1) * 256) + $urandom_range(0, 3));
            pd = ($urandom_range(0, 2) == 0) ? pe : 32'($urandom_range(0, 31) * 4);
            drive(int'($urandom_range(0, 7)), a, b, pe, pd, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0);
            do_cycle();
            if (n == 700) async_reset_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
